// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported, fixed-latency unified memory between the IF stage
//   (instruction fetch) and the MEM stage (load/store) of a 5-stage pipeline.
//   Every access is sequenced by a four-state FSM: IDLE -> ISSUE -> WAIT -> RESP.
//   DM wins simultaneous requests (older instruction).
//
//   Optional build macro ARB_STARVE_GUARD_EN:
//     When defined, a loss counter forces an IF grant after STARVE_MAX
//     consecutive DM wins that happened while IF was waiting.
//     When undefined, DM always has strict priority.
//
// Handshake: a requester raises *_req and holds it high until its *_ack pulse.
//   The ack pulse lasts one cycle, and read data is valid in that cycle.
//   Read data then holds until the next read for that requester.
//   A requester that drops req early still gets its access completed and acked.
//
// Ports
//   clk, reset             clock (rising edge); asynchronous active-low reset
//   if_req/if_addr         fetch request and byte address
//   if_rdata/if_ack        fetched instruction and completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata  data request (we and wdata sampled at grant)
//   dm_rdata/dm_ack/dm_err load data, completion pulse, misalignment flag
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port (word aligned)
//   stall_if/stall_mem     pipeline stall lines
//   dbg_state              current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              dm_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // The latency counter is loaded at grant and counts down through ISSUE and
   // WAIT. The read data is captured in the cycle where it reaches zero. That
   // places the ack exactly MEM_LAT cycles after mem_en.
   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t              state_q, state_d;
   logic                grant_dm_q, grant_dm_d;
   logic                we_q, we_d;
   logic                err_q, err_d;
   logic [ADDR_W-3:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
   logic                take_dm;
   logic                capture;
   logic                force_if;

   // The low fetch address bits have no meaning for word fetches.
   logic                unused_if_lsb;
   assign unused_if_lsb = ^if_addr[1:0];

`ifdef ARB_STARVE_GUARD_EN
   logic [3:0]          loss_q, loss_d;
   assign force_if = (loss_q == 4'(STARVE_MAX));
`else
   // No guard: the limit has no effect on arbitration.
   logic [3:0]          unused_starve;
   assign unused_starve = 4'(STARVE_MAX);
   assign force_if      = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Next-state and datapath logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      grant_dm_d = grant_dm_q;
      we_d       = we_q;
      err_d      = err_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      take_dm    = 1'b0;
      capture    = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      loss_d     = loss_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (if_req || dm_req) begin
               // DM wins unless the starvation guard has reserved this slot for IF.
               take_dm    = dm_req & ~(force_if & if_req);
               grant_dm_d = take_dm;
               addr_d     = take_dm ? dm_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
               we_d       = take_dm & dm_we;
               wdata_d    = take_dm ? dm_wdata : '0;
               err_d      = take_dm & (dm_addr[1:0] != 2'b00);
               cnt_d      = LAT_M1;
               state_d    = S_ISSUE;
`ifdef ARB_STARVE_GUARD_EN
               if (!take_dm)
                  loss_d = '0;
               else if (if_req)
                  loss_d = loss_q + 4'd1;
`endif
            end
         end
         S_ISSUE, S_WAIT: begin
            if (cnt_q == 4'd0) begin
               capture = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d   = cnt_q - 4'd1;
               state_d = S_WAIT;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A store leaves dm_rdata untouched.
      if (capture) begin
         if (grant_dm_q) begin
            if (!we_q)
               dm_rdata_d = mem_rdata;
         end else begin
            if_rdata_d = mem_rdata;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         grant_dm_q <= 1'b0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_dm_q <= grant_dm_d;
         we_q       <= we_d;
         err_q      <= err_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

`ifdef ARB_STARVE_GUARD_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         loss_q <= '0;
      else
         loss_q <= loss_d;
   end
`endif

   // ---------------------------------------------------------------------------
   // Outputs: decoded from registered state so that reset clears them at once.
   // ---------------------------------------------------------------------------
   assign mem_en    = (state_q == S_ISSUE);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = {addr_q, 2'b00};
   assign mem_wdata = wdata_q;
   assign if_ack    = (state_q == S_RESP) & ~grant_dm_q;
   assign dm_ack    = (state_q == S_RESP) &  grant_dm_q;
   assign dm_err    = dm_ack & err_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   // The stall lines are masked while reset is asserted.
   // This keeps the pipeline from freezing on a request that reset has discarded.
   assign stall_if  = reset & if_req & ~if_ack;
   assign stall_mem = reset & dm_req & ~dm_ack;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter.
//   Instance dut uses MEM_LAT=2; instance dut3 uses MEM_LAT=3.
//   Both instances share every input.
//   Inputs are driven on the falling edge, and outputs are sampled there too.
//   Cycle t is the cycle in which IDLE first sees the request.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;

   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_ack, dm_ack, dm_err, mem_en, mem_we, stall_if, stall_mem;
   logic [1:0]  dbg_state;

   logic [31:0] if_rdata3, dm_rdata3, mem_addr3, mem_wdata3;
   logic        if_ack3, dm_ack3, dm_err3, mem_en3, mem_we3, stall_if3, stall_mem3;
   logic [1:0]  dbg_state3;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   // clock / reset block
   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
      .dbg_state(dbg_state)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata3), .if_ack(if_ack3),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata3), .dm_ack(dm_ack3), .dm_err(dm_err3),
      .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
      .mem_rdata(mem_rdata), .stall_if(stall_if3), .stall_mem(stall_mem3),
      .dbg_state(dbg_state3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(2);
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
   endtask

   initial begin
      int          n;
      logic [31:0] exp_v;
      reset = 1'b0;
      idle_inputs();
      if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;

      // ---- reset state ----
      tick(2);
      check("rst_state", dbg_state, 32'd0);
      check("rst_mem_en", mem_en, 32'd0);
      check("rst_if_ack", if_ack, 32'd0);
      check("rst_dm_ack", dm_ack, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_dm_rdata", dm_rdata, 32'd0);
      reset = 1'b1;
      tick(2);

      // ---- 1: reset mid-WAIT, MEM_LAT=3 ----
      if_req = 1'b1; if_addr = 32'h20; mem_rdata = 32'h1111_1111;
      tick(1);                                        // t+1
      check("t1_mem_en_issue", mem_en3, 32'd1);
      tick(1);                                        // t+2, WAIT
      check("t1_state_wait", dbg_state3, 32'd2);
      reset = 1'b0;
      #1;
      check("t1_rst_mem_en", mem_en3, 32'd0);
      check("t1_rst_state", dbg_state3, 32'd0);
      check("t1_rst_if_ack", if_ack3, 32'd0);
      check("t1_rst_stall_if", stall_if3, 32'd0);
      tick(2);
      check("t1_rst_hold_ack", if_ack3, 32'd0);
      reset = 1'b1;                                   // req still high -> new t
      tick(1);                                        // t+1
      check("t1_re_mem_en", mem_en3, 32'd1);
      check("t1_re_ack_t1", if_ack3, 32'd0);
      tick(1);
      check("t1_re_ack_t2", if_ack3, 32'd0);
      tick(1);
      check("t1_re_ack_t3", if_ack3, 32'd0);
      tick(1);                                        // t+4
      check("t1_re_ack_t4", if_ack3, 32'd1);
      check("t1_re_rdata", if_rdata3, 32'h1111_1111);
      idle_inputs();
      tick(4);

      // ---- 2: single fetch, MEM_LAT=2 ----
      if_req = 1'b1; if_addr = 32'h40; mem_rdata = 32'h8C02_0004;
      tick(1);                                        // t+1
      check("t2_mem_en", mem_en, 32'd1);
      check("t2_mem_addr", mem_addr, 32'h40);
      check("t2_mem_we", mem_we, 32'd0);
      check("t2_stall_if", stall_if, 32'd1);
      tick(1);                                        // t+2
      check("t2_mem_en_off", mem_en, 32'd0);
      check("t2_ack_early", if_ack, 32'd0);
      tick(1);                                        // t+3
      check("t2_if_ack", if_ack, 32'd1);
      check("t2_if_rdata", if_rdata, 32'h8C02_0004);
      check("t2_stall_off", stall_if, 32'd0);
      idle_inputs();
      mem_rdata = 32'h5555_AAAA;
      tick(1);
      check("t2_ack_pulse", if_ack, 32'd0);
      check("t2_rdata_hold", if_rdata, 32'h8C02_0004);
      tick(4);

      // ---- 5: misaligned load ----
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h103; mem_rdata = 32'hCAFE_F00D;
      tick(1);
      check("t5_mem_addr", mem_addr, 32'h100);
      check("t5_stall_mem", stall_mem, 32'd1);
      tick(1);
      check("t5_err_early", dm_err, 32'd0);
      tick(1);                                        // t+3
      check("t5_dm_ack", dm_ack, 32'd1);
      check("t5_dm_err", dm_err, 32'd1);
      check("t5_dm_rdata", dm_rdata, 32'hCAFE_F00D);
      check("t5_if_rdata_hold", if_rdata, 32'h8C02_0004);
      idle_inputs();
      tick(1);
      check("t5_err_pulse", dm_err, 32'd0);
      tick(4);

      // ---- 3: aligned store ----
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
      mem_rdata = 32'h1234_5678;
      tick(1);
      check("t3_mem_en", mem_en, 32'd1);
      check("t3_mem_we", mem_we, 32'd1);
      check("t3_mem_addr", mem_addr, 32'h100);
      check("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      dm_wdata = 32'h0;                               // only the grant-time value matters
      tick(1);
      check("t3_wdata_stable", mem_wdata, 32'hDEAD_BEEF);
      check("t3_we_qualified", mem_we, 32'd0);
      tick(1);
      check("t3_dm_ack", dm_ack, 32'd1);
      check("t3_dm_err", dm_err, 32'd0);
      check("t3_dm_rdata_keep", dm_rdata, 32'hCAFE_F00D);
      idle_inputs();
      tick(4);

      // ---- 4: simultaneous requests ----
      if_req = 1'b1; if_addr = 32'h44;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; mem_rdata = 32'hAAAA_5555;
      #1;
      check("t4_stall_if_t0", stall_if, 32'd1);
      tick(1);                                        // t+1
      check("t4_dm_first", mem_addr, 32'h200);
      check("t4_stall_if_t1", stall_if, 32'd1);
      tick(2);                                        // t+3
      check("t4_dm_ack", dm_ack, 32'd1);
      check("t4_if_ack_none", if_ack, 32'd0);
      check("t4_dm_rdata", dm_rdata, 32'hAAAA_5555);
      check("t4_stall_if_t3", stall_if, 32'd1);
      dm_req = 1'b0;
      mem_rdata = 32'h0BAD_C0DE;
      tick(1);                                        // t+4 IDLE, grants IF
      check("t4_idle_gap", dbg_state, 32'd0);
      check("t4_stall_if_t4", stall_if, 32'd1);
      tick(1);                                        // t+5
      check("t4_if_issue", mem_en, 32'd1);
      check("t4_if_addr", mem_addr, 32'h44);
      tick(1);                                        // t+6
      check("t4_stall_if_t6", stall_if, 32'd1);
      check("t4_if_ack_t6", if_ack, 32'd0);
      tick(1);                                        // t+7
      check("t4_if_ack", if_ack, 32'd1);
      check("t4_if_rdata", if_rdata, 32'h0BAD_C0DE);
      check("t4_stall_if_t7", stall_if, 32'd0);
      idle_inputs();
      tick(4);

      // ---- 6: starvation behaviour under continuous requests ----
      do_reset();
`ifdef ARB_STARVE_GUARD_EN
      exp_q = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h80, 32'h300};
`else
      exp_q = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h300, 32'h300};
`endif
      if_req = 1'b1; if_addr = 32'h80;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; mem_rdata = 32'h7;
      n = 0;
      for (int cyc = 0; cyc < 80 && exp_q.size() > 0; cyc++) begin
         @(negedge clk);
         if (mem_en) begin
            exp_v = exp_q.pop_front();
            check($sformatf("t6_grant%0d", n), mem_addr, exp_v);
            n++;
         end
      end
      check("t6_grant_count", n, 32'd6);
      idle_inputs();
      tick(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
